hex_display_scheduler: RTL



---
 rtl/hex_disp_pkg.sv | 20 ++
 rtl/bin16_to_bcd_seq.sv | 81 ++++++++
 rtl/hex_display_scheduler.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/hex_disp_pkg.sv
// Shared definitions for the hex display scheduler and its BCD converter.
//   state_t       scheduler FSM states
//   BCD_MAX       saturated decimal reading shown for out-of-range values
//   BCD_LIMIT     first binary value that no longer fits in 4 BCD digits
//   CONV_LATENCY  cycles from converter start to its done pulse
package hex_disp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SELECT  = 3'd1,
        ST_CONVERT = 3'd2,
        ST_SHOW    = 3'd3,
        ST_ALERT   = 3'd4
    } state_t;

    localparam logic [15:0] BCD_MAX      = 16'h9999;
    localparam logic [15:0] BCD_LIMIT    = 16'd10000;
    localparam int          CONV_LATENCY = 17;

endpackage

// File: rtl/bin16_to_bcd_seq.sv
// Sequential 16-bit binary to 4-digit packed BCD converter (shift/add-3,
// one input bit per cycle). Inputs >= BCD_LIMIT saturate to BCD_MAX.
//   sys_clk  clock
//   sys_rst  asynchronous active-high reset
//   clr      abort any conversion in flight; no done follows
//   start    latch bin_in and begin converting
//   bin_in   binary value to convert
//   busy     conversion in progress
//   done     one-cycle pulse CONV_LATENCY cycles after start
//   bcd_out  result, valid while done is high and until the next start
module bin16_to_bcd_seq
    import hex_disp_pkg::*;
(
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        clr,
    input  logic        start,
    input  logic [15:0] bin_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] bcd_out
);

    localparam int CNT_W = $clog2(CONV_LATENCY);

    logic [15:0]      bin_reg;
    logic [15:0]      bcd_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             sat_reg;
    logic [11:0]      bcd_adj;

    // Add-3 correction on the three low digits. The top digit never reaches
    // 5 before its final shift for any value below BCD_LIMIT, and larger
    // values are replaced by BCD_MAX, so it only needs to shift.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_digit
            assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                        bcd_reg[4*gi +: 4] + 4'd3 :
                                        bcd_reg[4*gi +: 4];
        end
    endgenerate

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            bin_reg  <= '0;
            bcd_reg  <= '0;
            cnt_reg  <= '0;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
            sat_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (clr) begin
                busy_reg <= 1'b0;
            end else if (start) begin
                bin_reg  <= bin_in;
                bcd_reg  <= '0;
                cnt_reg  <= CNT_W'(CONV_LATENCY - 1);
                busy_reg <= 1'b1;
                sat_reg  <= (bin_in >= BCD_LIMIT);
            end else if (busy_reg) begin
                bcd_reg <= {bcd_reg[14:12], bcd_adj, bin_reg[15]};
                bin_reg <= {bin_reg[14:0], 1'b0};
                cnt_reg <= cnt_reg - 1'b1;
                // The last of the 16 shifts lands together with done.
                if (cnt_reg == CNT_W'(1)) begin
                    busy_reg <= 1'b0;
                    done_reg <= 1'b1;
                end
            end
        end
    end

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign bcd_out = sat_reg ? BCD_MAX : bcd_reg;

endmodule

// File: rtl/hex_display_scheduler.sv
// Time-shares one 4-digit hex display between NUM_CH sources in round-robin
// order, each shown for DWELL_CYCLES; an alert source pre-empts rotation and
// decimal-flagged sources are routed through the sequential BCD converter.
//   sys_clk       clock
//   sys_rst       asynchronous active-high reset
//   ch_value      packed 16-bit source values, channel i at [16i+15:16i]
//   ch_enable     per-channel participation in the rotation
//   ch_bcd        per-channel decimal (1) / hex (0) display
//   alert_req     level request to show alert_value
//   alert_value   alert value, shown hex, sampled once on alert entry
//   hold          freezes the dwell countdown
//   alert_ack     one-cycle pulse on alert entry
//   disp_value    nibble-packed value to the display mux
//   disp_enable   display on
//   disp_channel  channel currently shown
//   disp_alert    alert currently shown
module hex_display_scheduler
    import hex_disp_pkg::*;
#(
    parameter  int NUM_CH       = 4,
    parameter  int DWELL_CYCLES = 25000000,
    localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic [16*NUM_CH-1:0] ch_value,
    input  logic [NUM_CH-1:0]    ch_enable,
    input  logic [NUM_CH-1:0]    ch_bcd,
    input  logic                 alert_req,
    input  logic [15:0]          alert_value,
    input  logic                 hold,
    output logic                 alert_ack,
    output logic [15:0]          disp_value,
    output logic                 disp_enable,
    output logic [CH_W-1:0]      disp_channel,
    output logic                 disp_alert
);

    localparam int DW_W = $clog2(DWELL_CYCLES);

    state_t            state_reg, state_next;
    logic [CH_W-1:0]   ptr_reg;
    logic [DW_W-1:0]   dwell_reg;
    logic [15:0]       disp_value_reg;
    logic              disp_enable_reg;
    logic [CH_W-1:0]   disp_channel_reg;
    logic              disp_alert_reg;
    logic              alert_ack_reg;

    logic [15:0]       ch_word [NUM_CH];
    logic              grant_valid;
    logic [CH_W-1:0]   grant_idx;
    logic [CH_W-1:0]   cand;
    logic              conv_start, conv_clr, conv_busy, conv_done;
    logic [15:0]       conv_bcd;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_unpack
            assign ch_word[gi] = ch_value[16*gi +: 16];
        end
    endgenerate

    // Round-robin pick: first enabled channel after ptr, wrapping; ptr itself
    // is visited last, so a lone enabled channel is re-granted.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = CH_W'((int'(ptr_reg) + k) % NUM_CH);
            if (!grant_valid && ch_enable[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        conv_start = 1'b0;
        conv_clr   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (alert_req)       state_next = ST_ALERT;
                else if (|ch_enable) state_next = ST_SELECT;
            end
            ST_SELECT: begin
                if (alert_req)             state_next = ST_ALERT;
                else if (!grant_valid)     state_next = ST_IDLE;
                else if (ch_bcd[grant_idx]) begin
                    state_next = ST_CONVERT;
                    conv_start = 1'b1;
                end else                   state_next = ST_SHOW;
            end
            ST_CONVERT: begin
                if (alert_req)      state_next = ST_ALERT;
                else if (conv_done) state_next = ST_SHOW;
            end
            ST_SHOW: begin
                if (alert_req)                      state_next = ST_ALERT;
                else if (!ch_enable[ptr_reg])       state_next = ST_SELECT;
                else if (dwell_reg == '0 && !hold)  state_next = ST_SELECT;
            end
            ST_ALERT: begin
                if (!alert_req) state_next = ST_SELECT;
            end
            default: state_next = ST_IDLE;
        endcase
        // Leaving CONVERT with a conversion still running means it was
        // pre-empted; kill it so no late done can surface.
        conv_clr = conv_busy && (state_next != ST_CONVERT);
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_reg        <= ST_IDLE;
            ptr_reg          <= CH_W'(NUM_CH - 1);
            dwell_reg        <= '0;
            disp_value_reg   <= '0;
            disp_enable_reg  <= 1'b0;
            disp_channel_reg <= '0;
            disp_alert_reg   <= 1'b0;
            alert_ack_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            alert_ack_reg <= 1'b0;

            case (state_reg)
                ST_SELECT: begin
                    // ptr follows the grant even when an alert wins this
                    // cycle, so the alert exit re-grants this channel.
                    if (grant_valid) ptr_reg <= grant_idx;
                    if (state_next == ST_SHOW) begin
                        disp_value_reg   <= ch_word[grant_idx];
                        disp_channel_reg <= grant_idx;
                        disp_enable_reg  <= 1'b1;
                    end
                    if (state_next == ST_IDLE) disp_enable_reg <= 1'b0;
                end
                ST_CONVERT: begin
                    if (state_next == ST_SHOW) begin
                        disp_value_reg   <= conv_bcd;
                        disp_channel_reg <= ptr_reg;
                        disp_enable_reg  <= 1'b1;
                    end
                end
                ST_ALERT: begin
                    if (state_next == ST_SELECT) begin
                        disp_alert_reg <= 1'b0;
                        ptr_reg <= (ptr_reg == '0) ? CH_W'(NUM_CH - 1) : ptr_reg - 1'b1;
                    end
                end
                default: ;
            endcase

            if (state_next == ST_SHOW && state_reg != ST_SHOW)
                dwell_reg <= DW_W'(DWELL_CYCLES - 1);
            else if (state_reg == ST_SHOW && !hold && dwell_reg != '0)
                dwell_reg <= dwell_reg - 1'b1;

            if (state_next == ST_ALERT && state_reg != ST_ALERT) begin
                disp_value_reg  <= alert_value;
                disp_alert_reg  <= 1'b1;
                disp_enable_reg <= 1'b1;
                alert_ack_reg   <= 1'b1;
            end
        end
    end

    bin16_to_bcd_seq u_bcd (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .clr     (conv_clr),
        .start   (conv_start),
        .bin_in  (ch_word[grant_idx]),
        .busy    (conv_busy),
        .done    (conv_done),
        .bcd_out (conv_bcd)
    );

    assign alert_ack    = alert_ack_reg;
    assign disp_value   = disp_value_reg;
    assign disp_enable  = disp_enable_reg;
    assign disp_channel = disp_channel_reg;
    assign disp_alert   = disp_alert_reg;

endmodule
